md_unit_ctrl: RTL and testbench
===============================

# md_unit_ctrl

Multi-cycle multiply/divide controller that owns the HI/LO register pair of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo from the execute stage, sequences the operation over a fixed cycle count, and raises `busy` so hazard logic can stall md-dependent instructions. It commits results to HI/LO and drives the mfhi/mflo read path.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; op and operands valid this cycle.
- `md_op`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 no-op.
- `rs_val`  in  32  operand A / dividend / mthi-mtlo source.
- `rt_val`  in  32  operand B / divisor.
- `rd_hi`  in  1  read select: 1 = HI, 0 = LO.
- `busy`  out  1  operation in flight.
- `md_result`  out  32  committed HI or LO per `rd_hi`, combinational.
- `hi`, `lo`  out  32 each  committed register values.

## Operation
- States: IDLE, RUN. Down-counter `cnt`, width ⌈log2(max(MULT_CYCLES,DIV_CYCLES)+1)⌉.
- IDLE & `start` & op∈{0..3`}`: compute result into pending regs `p_hi`/`p_lo`; load `cnt` = MULT_CYCLES or DIV_CYCLES; → RUN.
- IDLE & `start` & op=4/5: HI (resp. LO) ← `rs_val` at that edge; stay IDLE; `busy` stays 0.
- IDLE & `start` & op 6–7: ignored.
- RUN: `cnt` decrements each edge; on the edge where `cnt`=1, HI←`p_hi`, LO←`p_lo`, → IDLE.
- `start` while RUN: ignored entirely (any op, including mthi/mtlo); upstream stall guarantees it does not occur, the block must still not corrupt state.
- Arithmetic: mult/multu 64-bit product, HI=[63:32], LO=[31:0]. div/divu LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder takes sign of dividend.
- Divide by zero: full DIV_CYCLES latency, HI/LO unchanged at commit.
- Signed 0x8000_0000 ÷ 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- `md_result` always reflects committed HI/LO, never pending values.

## Timing
- Reset (async assert): state IDLE, `cnt`=0, HI=LO=0, `p_hi`=`p_lo`=0, `busy`=0, `md_result`=0. Release synchronous to next edge.
- `busy` = (state==RUN), registered.
- mult/div sampled at edge E0: `busy`=1 for exactly N cycles after E0 (N=MULT_CYCLES/DIV_CYCLES); HI/LO update at edge E0+N; `busy`=0 and new value on `md_result` in the same cycle after E0+N.
- Back-to-back: a `start` in the first cycle `busy`=0 is accepted (no dead cycle).
- mthi/mtlo: value visible on `md_result` one cycle after the `start` cycle.
- Reset mid-RUN: operation abandoned, HI/LO cleared, no late commit.

## Structure
- Shared package `md_pkg`: `md_op` encodings, state enum, default cycle constants.
- Sub-module `md_arith`: purely combinational 32×32 signed/unsigned mult and div producing {hi,lo}, including div-by-zero flag and overflow case. Controller instantiates one copy.
- Output HI/LO select lives inside the controller.

## Test plan
- Reset then mult rs=0xFFFF_FFFF rt=2 (signed) → `busy` high 5 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFE.
- multu 0xFFFF_FFFF × 0xFFFF_FFFF → after 5 cycles HI=0xFFFF_FFFE, LO=0x0000_0001; `md_result` unchanged during busy.
- div −7 ÷ 2 → after 10 cycles LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1); divu 7÷0 → HI/LO retain prior values after 10 cycles.
- mthi 0x1234_5678 then mtlo 0x9ABC_DEF0 on consecutive cycles, `busy`=0 throughout → `rd_hi`=1 gives 0x1234_5678, `rd_hi`=0 gives 0x9ABC_DEF0.
- mthi issued at cycle 2 of a running mult → ignored; final HI = product high word.
- Assert `reset_n`=0 at cycle 3 of a div → `busy`, HI, LO go 0 immediately; no commit after release.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, controller
// state, default latencies and the {hi,lo} result payload.
package md_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // md_op encodings; 6 and 7 are no-ops
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // HI/LO result payload
    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } md_pair_t;

    // mult/multu/div/divu all have md_op[2] clear
    function automatic logic md_is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == 3'(MD_DIV)) || (op == 3'(MD_DIVU));
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 signed/unsigned multiply and divide.
// Ports:
//   op   - md_op encoding (mult/multu/div/divu; others yield the product)
//   a, b - operand A / dividend, operand B / divisor
//   res  - {hi,lo}: product [63:32]/[31:0], or remainder/quotient
//   div0 - divisor is zero (res is meaningless for divides in that case)
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output md_pair_t        res,
    output logic            div0
);

    localparam int unsigned PW = 2 * XLEN;

    logic            is_sgn;
    logic            is_div;
    logic            a_neg;
    logic            b_neg;
    logic            ovf;
    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   b_ext;
    logic [PW-1:0]   prod;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] b_safe;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;

    // Sign-extended operands make a single unsigned multiplier serve both
    // signednesses; divide works on magnitudes and fixes signs afterwards.
    always_comb begin
        is_sgn = (op == 3'(MD_MULT)) || (op == 3'(MD_DIV));
        is_div = md_is_div(op);
        a_neg  = is_sgn & a[XLEN-1];
        b_neg  = is_sgn & b[XLEN-1];

        a_ext  = {{XLEN{a_neg}}, a};
        b_ext  = {{XLEN{b_neg}}, b};
        prod   = a_ext * b_ext;

        a_mag  = a_neg ? (~a + XLEN'(1)) : a;
        b_mag  = b_neg ? (~b + XLEN'(1)) : b;
        div0   = (b == '0);
        b_safe = div0 ? XLEN'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;

        // quotient truncates toward zero, remainder follows the dividend
        q      = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
        r      = a_neg ? (~r_mag + XLEN'(1)) : r_mag;

        // most-negative / -1 wraps to itself with zero remainder
        ovf    = is_sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (ovf) begin
            q = 32'h8000_0000;
            r = '0;
        end

        if (is_div) begin
            res.hi = r;
            res.lo = q;
        end else begin
            res.hi = prod[PW-1:XLEN];
            res.lo = prod[XLEN-1:0];
        end
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO register pair.
// Ports:
//   clk, reset_n      - core clock, async active-low reset
//   start, md_op      - one-cycle request and its operation
//   rs_val, rt_val    - operands (rs_val also feeds mthi/mtlo)
//   rd_hi             - md_result select: 1 = HI, 0 = LO
//   busy              - operation in flight (registered)
//   md_result         - committed HI or LO (combinational mux)
//   hi, lo            - committed register values
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            rd_hi,
    output logic            busy,
    output logic [XLEN-1:0] md_result,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e       state;
    md_state_e       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] lo_d;
    logic [XLEN-1:0] p_hi;
    logic [XLEN-1:0] p_hi_d;
    logic [XLEN-1:0] p_lo;
    logic [XLEN-1:0] p_lo_d;
    logic            busy_q;
    logic            last_c;

    md_pair_t        arith_res;
    logic            arith_div0;

    md_arith u_arith (
        .op   (md_op),
        .a    (rs_val),
        .b    (rt_val),
        .res  (arith_res),
        .div0 (arith_div0)
    );

    // final cycle of a running operation (<= guards a corrupted zero count)
    assign last_c = (cnt <= CNT_W'(1));

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            p_hi   <= p_hi_d;
            p_lo   <= p_lo_d;
            busy_q <= (state_d == ST_RUN);
        end
    end

    // Next-state logic; requests during RUN are ignored
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (start && md_is_arith(md_op)) state_d = ST_RUN;
            ST_RUN:  if (last_c)                      state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture pending result, count down, commit
    always_comb begin
        cnt_d  = cnt;
        hi_d   = hi_q;
        lo_d   = lo_q;
        p_hi_d = p_hi;
        p_lo_d = p_lo;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (md_is_arith(md_op)) begin
                        // divide by zero commits the current HI/LO back unchanged
                        if (md_is_div(md_op) && arith_div0) begin
                            p_hi_d = hi_q;
                            p_lo_d = lo_q;
                        end else begin
                            p_hi_d = arith_res.hi;
                            p_lo_d = arith_res.lo;
                        end
                        cnt_d = md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end else if (md_op == 3'(MD_MTHI)) begin
                        hi_d = rs_val;
                    end else if (md_op == 3'(MD_MTLO)) begin
                        lo_d = rs_val;
                    end
                end
            end
            ST_RUN: begin
                if (last_c) begin
                    cnt_d = '0;
                    hi_d  = p_hi;
                    lo_d  = p_lo;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign md_result = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: vector table run through a scoreboard, plus
// hand-written sequences for ignored requests and reset mid-operation.
module tb_md_unit_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_hi;
    logic        busy;
    logic [31:0] md_result;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .rd_hi     (rd_hi),
        .busy      (busy),
        .md_result (md_result),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[12];
    int          n_cmp;
    int          n_bad;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Called at a negedge: drives one request, tracks busy, then checks the
    // popped expectation against HI, LO and both md_result selections.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input int ecyc);
        exp_t e;
        int   n;
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        sb.push_back('{hi: ehi, lo: elo, cyc: ecyc});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            if (md_result !== cur_lo) chk({name, " result_held"}, md_result, cur_lo);
            n++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            chk({name, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({name, " busy_cycles"}, 32'(n), 32'(e.cyc));
            chk({name, " hi"}, hi, e.hi);
            chk({name, " lo"}, lo, e.lo);
            chk({name, " result_lo"}, md_result, e.lo);
            rd_hi = 1'b1;
            #1;
            chk({name, " result_hi"}, md_result, e.hi);
            rd_hi = 1'b0;
            cur_hi = e.hi;
            cur_lo = e.lo;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_cmp   = 0;
        n_bad   = 0;
        cur_hi  = '0;
        cur_lo  = '0;
        reset_n = 1'b0;
        start   = 1'b0;
        md_op   = 3'd7;
        rs_val  = '0;
        rt_val  = '0;
        rd_hi   = 1'b0;

        //                op    a             b             exp hi        exp lo        busy
        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5]  = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10};
        vecs[6]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        vecs[7]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[8]  = '{3'd4, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFD, 0};
        vecs[9]  = '{3'd5, 32'h9ABC_DEF0, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 0};
        vecs[10] = '{3'd6, 32'h5555_5555, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 0};
        vecs[11] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst result", md_result, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // vector table, each request issued in the first non-busy cycle
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cyc);
        end

        // mthi arriving in cycle 2 of a running mult must be dropped
        start  = 1'b1;
        md_op  = 3'd0;
        rs_val = 32'd3;
        rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'd4;
        rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("mthi_in_run busy_cycles", 32'(n), 32'd5);
        chk("mthi_in_run hi", hi, 32'd0);
        chk("mthi_in_run lo", lo, 32'd12);
        @(negedge clk);
        chk("mthi_in_run hi_later", hi, 32'd0);

        // reset asserted in cycle 3 of a divide
        start  = 1'b1;
        md_op  = 3'd4;
        rs_val = 32'h5555_5555;
        @(negedge clk);
        md_op  = 3'd2;
        rs_val = 32'd100;
        rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst busy", 32'(busy), 32'd1);
        chk("pre_rst hi", hi, 32'h5555_5555);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst busy", 32'(busy), 32'd0);
        chk("mid_rst hi", hi, 32'd0);
        chk("mid_rst lo", lo, 32'd0);
        chk("mid_rst result", md_result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst busy", 32'(busy), 32'd0);
        chk("post_rst hi", hi, 32'd0);
        chk("post_rst lo", lo, 32'd0);

        // unit still operational after reset
        cur_hi = '0;
        cur_lo = '0;
        run_op("after_rst", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
